serial_byte_rx: RTL and testbench
=================================

SERIAL_BYTE_RX -- requirements
Module: serial_byte_rx

Interface
REQ-001 Parameter MSB_FIRST, default 1; 1 = first received bit lands in OUT[7], 0 = first bit lands in OUT[0].
REQ-002 CLK  input  1  single clock, all state updates on rising edge.
REQ-003 RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SIN  input  1  serial data bit, sampled only when SVALID=1.
REQ-005 SVALID  input  1  SIN carries a valid bit this cycle.
REQ-006 START  input  1  frame start; qualifies the SIN bit sampled with it as bit 0 of a new frame.
REQ-007 OUT  output  8  assembled byte, registered.
REQ-008 OUT_VALID  output  1  OUT holds an unconsumed byte.
REQ-009 OUT_READY  input  1  consumer accepts OUT; transfer = OUT_VALID & OUT_READY at a rising edge.
REQ-010 NZ  output  1  8-way OR of OUT.
REQ-011 COUNT  output  4  bits collected in the current frame, 0..7.
REQ-012 OVERRUN  output  1  sticky flag: a completed byte was dropped.
REQ-013 CLR_OVR  input  1  synchronous clear of OVERRUN.

Function
REQ-014 The FSM SHALL have two states: IDLE and SHIFT; the shift register is separate from OUT (double-buffered).
REQ-015 IDLE: SVALID=1 & START=1 -> capture SIN as bit 0, COUNT=1, go to SHIFT; SVALID=1 & START=0 -> bit ignored; START with SVALID=0 -> ignored.
REQ-016 SHIFT: SVALID=1 & START=0 -> capture SIN as the next bit, COUNT+1; SVALID=0 -> no change.
REQ-017 SHIFT: SVALID=1 & START=1 -> abort the partial frame, capture SIN as bit 0, COUNT=1, stay in SHIFT.
REQ-018 Bit placement: MSB_FIRST=1 -> the shift register shifts left, SIN enters the LSB, and the first bit ends in OUT[7]; MSB_FIRST=0 -> it shifts right, SIN enters the MSB, and the first bit ends in OUT[0].
REQ-019 On the edge that samples the 8th bit: if OUT_VALID=0 or OUT_READY=1, OUT loads the assembled byte and OUT_VALID=1 after that same edge (zero-cycle latency beyond the 8th sample).
REQ-020 On the edge that samples the 8th bit: if OUT_VALID=1 and OUT_READY=0, the new byte is discarded, OUT is unchanged, and OVERRUN=1.
REQ-021 After the 8th bit the state is IDLE and COUNT=0, unless START=1 on a later cycle (REQ-015).
REQ-022 A transfer without a simultaneous completion -> OUT_VALID=0 after the edge; OUT retains its value.
REQ-023 OUT SHALL be stable while OUT_VALID=1 and OUT_READY=0.
REQ-024 NZ SHALL equal |OUT at all times, combinational from the OUT register; it is independent of OUT_VALID.
REQ-025 OVERRUN stays 1 until CLR_OVR=1 at an edge; if CLR_OVR and a new overrun coincide, OVERRUN=1.
REQ-026 COUNT never reaches 8; it wraps 7->0 on completion.

Reset
REQ-027 RST_N=0 SHALL immediately force: state IDLE, shift register 0, COUNT=0, OUT=8'h00, OUT_VALID=0, NZ=0, OVERRUN=0.
REQ-028 A reset mid-frame discards the partial byte; the first frame after RST_N rises needs START.
REQ-029 Deassertion of RST_N takes effect on the next rising edge; no bit is sampled on the edge where RST_N is 0.

Verification
REQ-030 MSB_FIRST=1, START with the first bit, SIN=1,0,1,0,0,1,0,1 on 8 consecutive SVALID cycles, OUT_READY=0 -> OUT=8'hA5, OUT_VALID=1 and NZ=1 after the 8th edge.
REQ-031 MSB_FIRST=0, same bit sequence -> OUT=8'hA5 (bit-reversed order giving the same pattern); sequence 1,0,0,0,0,0,0,0 -> OUT=8'h01.
REQ-032 Eight zero bits -> OUT=8'h00, OUT_VALID=1, NZ=0; SVALID gaps of 3 cycles between bits -> same result, COUNT holds through the gaps.
REQ-033 Byte A is held with OUT_READY=0 and byte B completes -> OUT=A, OVERRUN=1; CLR_OVR pulse -> OVERRUN=0; OUT_READY=1 on B's completion edge -> OUT=B, OUT_VALID stays 1.
REQ-034 START after 5 bits, then 8 new bits 1,1,1,1,0,0,0,0 (MSB_FIRST=1) -> OUT=8'hF0; the partial byte is never output.
REQ-035 RST_N low after 4 bits with OUT=8'hA5 valid -> OUT=0, OUT_VALID=0, COUNT=0, NZ=0 immediately (no clock); a following full frame completes normally.

Source files
------------

// File: rtl/serial_byte_rx.sv
// Serial-to-byte receiver: START-framed bit stream assembled into a double-buffered
// byte with a valid/ready output handshake and a sticky overrun flag.
module serial_byte_rx #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sin,
    input  logic       svalid,
    input  logic       start,
    input  logic       out_ready,
    input  logic       clr_ovr,
    output logic [7:0] out,
    output logic       out_valid,
    output logic       nz,
    output logic [3:0] count,
    output logic       overrun
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] sreg;
    logic [7:0] sreg_first;
    logic [7:0] sreg_shifted;
    logic       load_first;
    logic       shift_bit;
    logic       complete;
    logic       accept;
    logic       drop;

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: START always (re)opens a frame, the 8th bit closes it.
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (svalid && start) state_next = SHIFT;
            SHIFT: if (svalid && !start && count == 4'd7) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control decode for the datapath.
    always_comb begin
        load_first = svalid && start;
        shift_bit  = (state == SHIFT) && svalid && !start;
        complete   = shift_bit && (count == 4'd7);
        accept     = complete && (!out_valid || out_ready);
        drop       = complete && out_valid && !out_ready;
    end

    // The shift direction decides which end of the byte the first bit migrates to.
    always_comb begin
        if (MSB_FIRST) begin
            sreg_first   = {7'b0, sin};
            sreg_shifted = {sreg[6:0], sin};
        end else begin
            sreg_first   = {sin, 7'b0};
            sreg_shifted = {sin, sreg[7:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg  <= 8'h00;
            count <= 4'd0;
        end else if (load_first) begin
            sreg  <= sreg_first;
            count <= 4'd1;
        end else if (shift_bit) begin
            sreg  <= complete ? 8'h00 : sreg_shifted;
            count <= complete ? 4'd0 : count + 4'd1;
        end
    end

    // Output buffer: a completing byte may replace one being consumed on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else if (accept) begin
            out       <= sreg_shifted;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // A new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (drop) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

    assign nz = |out;

endmodule

// File: tb/tb_serial_byte_rx.sv
// Self-checking bench for serial_byte_rx: both bit orders side by side, a vector
// table, directed multi-cycle sequences and randomized traffic against a frame model.
module tb_serial_byte_rx;

    logic       clk;
    logic       rst_n;
    logic       sin;
    logic       svalid;
    logic       start;
    logic       out_ready;
    logic       clr_ovr;
    logic [7:0] out_m, out_l;
    logic       vld_m, vld_l, nz_m, nz_l, ovr_m, ovr_l;
    logic [3:0] cnt_m, cnt_l;

    int n_cmp  = 0;
    int n_fail = 0;

    serial_byte_rx #(.MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .svalid(svalid), .start(start),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .out(out_m), .out_valid(vld_m),
        .nz(nz_m), .count(cnt_m), .overrun(ovr_m)
    );

    serial_byte_rx #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .sin(sin), .svalid(svalid), .start(start),
        .out_ready(out_ready), .clr_ovr(clr_ovr), .out(out_l), .out_valid(vld_l),
        .nz(nz_l), .count(cnt_l), .overrun(ovr_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model: frames as a list of received bits ----------------
    bit         q[$];
    logic [7:0] m_out_msb, m_out_lsb;
    bit         m_vld, m_ovr;

    task automatic model_reset();
        q.delete();
        m_out_msb = 8'h00;
        m_out_lsb = 8'h00;
        m_vld     = 1'b0;
        m_ovr     = 1'b0;
    endtask

    task automatic model_edge();
        bit xfer = m_vld && out_ready;
        bit done = 1'b0;
        bit take = 1'b0;
        if (svalid && start) begin
            q.delete();
            q.push_back(sin);
        end else if (svalid && q.size() > 0) begin
            q.push_back(sin);
            if (q.size() == 8) begin
                done = 1'b1;
                take = !m_vld || out_ready;
                if (take) begin
                    for (int i = 0; i < 8; i++) begin
                        m_out_msb[7-i] = q[i];
                        m_out_lsb[i]   = q[i];
                    end
                end
                q.delete();
            end
        end
        if (take) m_vld = 1'b1;
        else if (xfer) m_vld = 1'b0;
        if (done && !take) m_ovr = 1'b1;
        else if (clr_ovr) m_ovr = 1'b0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_model(input string tag);
        check({tag, " out_msb"}, out_m, m_out_msb);
        check({tag, " out_lsb"}, out_l, m_out_lsb);
        check({tag, " valid"}, {7'b0, vld_m}, {7'b0, m_vld});
        check({tag, " valid_lsb"}, {7'b0, vld_l}, {7'b0, m_vld});
        check({tag, " count"}, {4'b0, cnt_m}, 8'(q.size()));
        check({tag, " overrun"}, {7'b0, ovr_m}, {7'b0, m_ovr});
        check({tag, " nz"}, {7'b0, nz_m}, {7'b0, (m_out_msb != 8'h00)});
    endtask

    task automatic drive(input logic sv, input logic st, input logic si,
                         input logic rdy, input logic clr);
        svalid = sv; start = st; sin = si; out_ready = rdy; clr_ovr = clr;
    endtask

    // Sends b[7] first with START on the first bit; ready/clear apply on the last bit.
    task automatic send_byte(input logic [7:0] b, input logic rdy_last, input logic clr_last);
        for (int i = 7; i >= 0; i--) begin
            drive(1'b1, i == 7, b[i], (i == 0) ? rdy_last : 1'b0, (i == 0) ? clr_last : 1'b0);
            step();
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy, input logic clr);
        drive(1'b0, 1'b0, 1'b0, rdy, clr);
        for (int i = 0; i < n; i++) step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       sv, st, si, rdy, clr;
        logic [7:0] e_msb, e_lsb;
        logic       e_vld;
        logic [3:0] e_cnt;
        logic       e_ovr;
    } vec_t;

    function automatic vec_t mk(input logic sv, input logic st, input logic si,
                                input logic rdy, input logic clr,
                                input logic [7:0] e_msb, input logic [7:0] e_lsb,
                                input logic e_vld, input logic [3:0] e_cnt, input logic e_ovr);
        vec_t v;
        v.sv = sv; v.st = st; v.si = si; v.rdy = rdy; v.clr = clr;
        v.e_msb = e_msb; v.e_lsb = e_lsb; v.e_vld = e_vld; v.e_cnt = e_cnt; v.e_ovr = e_ovr;
        return v;
    endfunction

    vec_t vecs[13];

    initial begin
        // Idle bits and unqualified START are ignored, then frame 1,0,1,0,0,1,0,1 with a gap.
        vecs[0]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
        vecs[1]  = mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd0, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd1, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b0);
        vecs[4]  = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd2, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd3, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd4, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd5, 1'b0);
        vecs[8]  = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd6, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'd7, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b1, 4'd0, 1'b0);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 8'hA5, 1'b0, 4'd0, 1'b0);
        vecs[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 8'hA5, 1'b0, 4'd0, 1'b0);

        // ---- reset ----
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset out", out_m, 8'h00);
        check("reset valid", {7'b0, vld_m}, 8'h00);
        check("reset count", {4'b0, cnt_m}, 8'h00);
        check("reset nz", {7'b0, nz_m}, 8'h00);
        check("reset overrun", {7'b0, ovr_m}, 8'h00);
        rst_n = 1'b1;

        // ---- table ----
        foreach (vecs[i]) begin
            drive(vecs[i].sv, vecs[i].st, vecs[i].si, vecs[i].rdy, vecs[i].clr);
            step();
            check($sformatf("vec%0d out_msb", i), out_m, vecs[i].e_msb);
            check($sformatf("vec%0d out_lsb", i), out_l, vecs[i].e_lsb);
            check($sformatf("vec%0d valid", i), {7'b0, vld_m}, {7'b0, vecs[i].e_vld});
            check($sformatf("vec%0d count", i), {4'b0, cnt_m}, {4'b0, vecs[i].e_cnt});
            check($sformatf("vec%0d overrun", i), {7'b0, ovr_m}, {7'b0, vecs[i].e_ovr});
            check($sformatf("vec%0d nz", i), {7'b0, nz_m}, {7'b0, vecs[i].e_msb != 8'h00});
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // ---- first bit only: 1,0,0,0,0,0,0,0 ----
        send_byte(8'h80, 1'b1, 1'b0);
        check("single bit out_lsb", out_l, 8'h01);
        check("single bit out_msb", out_m, 8'h80);
        check("single bit valid", {7'b0, vld_l}, 8'h01);
        idle(1, 1'b1, 1'b0);

        // ---- eight zeros with 3-cycle gaps ----
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, 1'b0, 1'b0, 1'b0);
            step();
            if (i < 7) begin
                idle(3, 1'b0, 1'b0);
                check($sformatf("gap count %0d", i + 1), {4'b0, cnt_m}, 8'(i + 1));
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("zeros out", out_m, 8'h00);
        check("zeros valid", {7'b0, vld_m}, 8'h01);
        check("zeros nz", {7'b0, nz_m}, 8'h00);
        idle(1, 1'b1, 1'b0);

        // ---- overrun: A held, B dropped, clear, then B on a consuming edge ----
        send_byte(8'h3C, 1'b0, 1'b0);
        send_byte(8'hC3, 1'b0, 1'b0);
        check("ovr held out", out_m, 8'h3C);
        check("ovr flag set", {7'b0, ovr_m}, 8'h01);
        idle(2, 1'b0, 1'b0);
        check("ovr sticky", {7'b0, ovr_m}, 8'h01);
        check("ovr out stable", out_m, 8'h3C);
        idle(1, 1'b0, 1'b1);
        check("ovr cleared", {7'b0, ovr_m}, 8'h00);
        send_byte(8'h5A, 1'b1, 1'b0);
        check("replace out", out_m, 8'h5A);
        check("replace valid", {7'b0, vld_m}, 8'h01);
        check("replace no ovr", {7'b0, ovr_m}, 8'h00);
        send_byte(8'hFF, 1'b0, 1'b1);
        check("ovr beats clear", {7'b0, ovr_m}, 8'h01);
        check("ovr beats clear out", out_m, 8'h5A);
        idle(1, 1'b1, 1'b1);
        compare_model("after ovr");

        // ---- abort after 5 bits, then F0 ----
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
            step();
        end
        check("partial count", {4'b0, cnt_m}, 8'h05);
        send_byte(8'hF0, 1'b1, 1'b0);
        check("abort out", out_m, 8'hF0);
        check("abort out_lsb", out_l, 8'h0F);
        check("abort valid", {7'b0, vld_m}, 8'h01);
        idle(1, 1'b1, 1'b0);

        // ---- async reset mid-frame with A5 valid ----
        send_byte(8'hA5, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, 1'b1, 1'b0, 1'b0);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("async rst out", out_m, 8'h00);
        check("async rst valid", {7'b0, vld_m}, 8'h00);
        check("async rst count", {4'b0, cnt_m}, 8'h00);
        check("async rst nz", {7'b0, nz_m}, 8'h00);
        model_reset();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("no sample in reset", {4'b0, cnt_m}, 8'h00);
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        check("needs start", {4'b0, cnt_m}, 8'h00);
        send_byte(8'h96, 1'b0, 1'b0);
        check("post rst frame", out_m, 8'h96);
        check("post rst valid", {7'b0, vld_m}, 8'h01);
        compare_model("post rst");

        // ---- randomized traffic ----
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom % 4) != 0, ($urandom % 16) == 0, 1'($urandom),
                  ($urandom % 3) == 0, ($urandom % 20) == 0);
            step();
            compare_model($sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
